bitcell_array_ctrl: RTL and testbench

- Sequencing controller that sits directly upstream of a ROWS x WORD_W array of bitcell latches.
- Each bitcell is level-sensitive (inputs data/sel/rw, output out):
  - writes when sel=1, rw=1;
  - drives its stored value on out when sel=1, rw=0;
  - out=0 when sel=0.
- Converts single-word read/write requests (valid/ready) into glitch-safe cell_sel/cell_rw/cell_data sequences and captures read data from the array.
- Array column outputs are OR-combined across rows externally, so only the selected row contributes to cell_out.

---
 rtl/bitcell_array_ctrl.sv | 156 +++++++++++++++
 tb/tb_bitcell_array_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitcell_array_ctrl.sv
// bitcell_array_ctrl
//   Sequencing controller for a ROWS x WORD_W array of level-sensitive
//   bitcell latches. It turns single-word read/write requests into a
//   glitch-safe sequence in which cell_rw/cell_data settle before the row
//   select rises and stay put until after it falls. On reads it captures
//   the OR-combined column bus.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_valid  request present
//   req_ready  controller idle and able to accept a request
//   req_we     1 = write, 0 = read
//   req_addr   row address
//   req_wdata  write data
//   rsp_valid  one-cycle completion pulse
//   rsp_err    address was out of range (valid with rsp_valid)
//   rsp_rdata  read data (valid with rsp_valid, held between responses)
//   cell_sel   one-hot row select, all-zero when not strobing
//   cell_rw    shared read/write control for all rows
//   cell_data  shared write-data bus for all rows
//   cell_out   OR of all row outputs
module bitcell_array_ctrl #(
  parameter int ROWS     = 16,
  parameter int ADDR_W   = 4,
  parameter int WORD_W   = 8,
  parameter int WR_PULSE = 2,
  parameter int RD_WAIT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic [ROWS-1:0]   cell_sel,
  output logic              cell_rw,
  output logic [WORD_W-1:0] cell_data,
  input  logic [WORD_W-1:0] cell_out
);

  localparam int MAXP  = (WR_PULSE > RD_WAIT) ? WR_PULSE : RD_WAIT;
  localparam int CNT_W = (MAXP > 1) ? $clog2(MAXP) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;
  logic [WORD_W-1:0]   r_rdata;

  logic                w_accept;
  logic                w_addr_err;
  logic                w_last;
  logic [ROWS-1:0]     w_onehot;

  assign w_accept   = req_valid & r_ready;
  assign w_addr_err = (int'(req_addr) >= ROWS);
  assign w_last     = (r_cnt == '0);
  assign w_onehot   = ROWS'(1) << r_addr;

  // State register. req_ready is registered so it stays low throughout
  // reset and rises on the first cycle after release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == IDLE);
    end
  end

  // Next-state logic. Out-of-range addresses skip the array entirely.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = w_addr_err ? RESP : SETUP;
      SETUP:   w_next = STROBE;
      STROBE:  if (w_last) w_next = r_we ? HOLD : RESP;
      HOLD:    w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output logic. rw/data are driven identically in SETUP, STROBE and HOLD
  // so they can only change while the select is low.
  always_comb begin
    cell_sel  = '0;
    cell_rw   = 1'b0;
    cell_data = '0;
    rsp_valid = 1'b0;
    unique case (r_state)
      SETUP, HOLD: begin
        cell_rw   = r_we;
        cell_data = r_we ? r_wdata : '0;
      end
      STROBE: begin
        cell_rw   = r_we;
        cell_data = r_we ? r_wdata : '0;
        cell_sel  = w_onehot;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign req_ready = r_ready;
  assign rsp_err   = (r_state == RESP) & r_err;
  assign rsp_rdata = r_rdata;

  // Request capture: inputs are frozen at acceptance.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Strobe-length down-counter, loaded at acceptance with (length - 1).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= req_we ? CNT_W'(WR_PULSE - 1) : CNT_W'(RD_WAIT - 1);
      r_err <= w_addr_err;
    end else if (r_state == STROBE && !w_last) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Read data is sampled at the end of the last strobe cycle; writes and
  // errored requests report zero as they enter RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (r_state == STROBE && w_last && !r_we) begin
      r_rdata <= cell_out;
    end else if (w_next == RESP && r_state != STROBE) begin
      r_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// Testbench for bitcell_array_ctrl: behavioural latch array, scoreboard of
// expected responses and a negedge monitor that checks responses and the
// select/rw/data invariants.
module tb_bitcell_array_ctrl;
  localparam int ROWS     = 12;
  localparam int ADDR_W   = 4;
  localparam int WORD_W   = 8;
  localparam int WR_PULSE = 2;
  localparam int RD_WAIT  = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [WORD_W-1:0] rsp_rdata;
  logic [ROWS-1:0]   cell_sel;
  logic              cell_rw;
  logic [WORD_W-1:0] cell_data;
  logic [WORD_W-1:0] cell_out;

  always #5 clk = ~clk;

  bitcell_array_ctrl #(
    .ROWS(ROWS), .ADDR_W(ADDR_W), .WORD_W(WORD_W),
    .WR_PULSE(WR_PULSE), .RD_WAIT(RD_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .cell_sel(cell_sel), .cell_rw(cell_rw), .cell_data(cell_data),
    .cell_out(cell_out)
  );

  // Level-sensitive bitcell array; outputs OR-combined across rows.
  logic [WORD_W-1:0] arr [ROWS];
  initial for (int r = 0; r < ROWS; r++) arr[r] = '0;
  always @(negedge clk)
    for (int r = 0; r < ROWS; r++)
      if (cell_sel[r] && cell_rw) arr[r] <= cell_data;
  always_comb begin
    cell_out = '0;
    for (int r = 0; r < ROWS; r++)
      if (cell_sel[r] && !cell_rw) cell_out = cell_out | arr[r];
  end

  typedef struct {
    bit                err;
    logic [WORD_W-1:0] rdata;
    int                due;
    int                strobes;
    logic [ROWS-1:0]   sel;
  } exp_t;

  exp_t              q[$];
  logic [WORD_W-1:0] ref_mem [ROWS];
  int                tests = 0;
  int                fails = 0;
  int                cyc = 0;
  int                sel_cnt = 0;
  logic              prev_rw = 1'b0;
  logic [WORD_W-1:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: invariants on every strobe cycle, scoreboard pop on rsp_valid.
  always @(negedge clk) begin : mon
    exp_t e;
    if (cell_sel != '0) begin
      sel_cnt++;
      chk("sel_popcount_le1", 32'($countones(cell_sel) <= 1), 32'(1));
      chk("rw_stable_under_sel", 32'(cell_rw), 32'(prev_rw));
      chk("data_stable_under_sel", 32'(cell_data), 32'(prev_data));
      if (q.size() == 0) chk("sel_without_request", 32'(cell_sel), 32'(0));
      else               chk("sel_row", 32'(cell_sel), 32'(q[0].sel));
    end
    if (rsp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'(0));
      end else begin
        e = q.pop_front();
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        chk("rsp_latency", 32'(cyc), 32'(e.due));
        chk("strobe_cycles", 32'(sel_cnt), 32'(e.strobes));
      end
      sel_cnt = 0;
    end
    prev_rw   = cell_rw;
    prev_data = cell_data;
    if (!rst_n) begin
      q.delete();
      sel_cnt = 0;
    end
  end

  // Issue one request, called just after a rising edge. Returns one cycle
  // after acceptance with the inputs scrambled.
  task automatic issue(input bit we, input int a, input logic [WORD_W-1:0] d, input bit hold);
    exp_t e;
    int   k;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = ADDR_W'(a);
    req_wdata = d;
    k = 0;
    while (!req_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'(1));
      req_valid = 1'b0;
      return;
    end
    e.err     = (a >= ROWS);
    e.sel     = e.err ? '0 : (ROWS'(1) << a);
    e.strobes = e.err ? 0 : (we ? WR_PULSE : RD_WAIT);
    e.due     = cyc + (e.err ? 1 : (we ? WR_PULSE + 3 : RD_WAIT + 2));
    e.rdata   = (e.err || we) ? '0 : ref_mem[a];
    if (!e.err && we) ref_mem[a] = d;
    q.push_back(e);
    @(posedge clk); #1;
    req_addr  = ADDR_W'($urandom);
    req_wdata = WORD_W'($urandom);
    req_we    = 1'($urandom);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_pending", 32'(q.size()), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    for (int r = 0; r < ROWS; r++) ref_mem[r] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_err", 32'(rsp_err), 32'(0));
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
    chk("rst_cell_sel", 32'(cell_sel), 32'(0));
    chk("rst_cell_rw", 32'(cell_rw), 32'(0));
    chk("rst_cell_data", 32'(cell_data), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", 32'(req_ready), 32'(1));

    // Write 0xA5 to row 3, walking the cell-side sequence cycle by cycle.
    issue(1'b1, 3, 8'hA5, 1'b0);
    chk("t1_setup_sel", 32'(cell_sel), 32'(0));
    chk("t1_setup_rw", 32'(cell_rw), 32'(1));
    chk("t1_setup_data", 32'(cell_data), 32'hA5);
    @(posedge clk); #1;
    chk("t1_strobe1_sel", 32'(cell_sel), 32'h008);
    @(posedge clk); #1;
    chk("t1_strobe2_sel", 32'(cell_sel), 32'h008);
    @(posedge clk); #1;
    chk("t1_hold_sel", 32'(cell_sel), 32'(0));
    chk("t1_hold_rw", 32'(cell_rw), 32'(1));
    chk("t1_hold_data", 32'(cell_data), 32'hA5);
    @(posedge clk); #1;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'(1));
    drain();

    // Read back row 3.
    issue(1'b0, 3, 8'h00, 1'b0);
    drain();

    // Neighbouring rows do not disturb each other.
    issue(1'b1, 3, 8'h00, 1'b0);
    issue(1'b1, 4, 8'hFF, 1'b0);
    issue(1'b0, 3, 8'h00, 1'b0);
    issue(1'b0, 4, 8'h00, 1'b0);
    drain();

    // Out-of-range rows, including the last valid row.
    issue(1'b1, 13, 8'h55, 1'b0);
    issue(1'b0, 13, 8'h00, 1'b0);
    issue(1'b1, ROWS - 1, 8'h5A, 1'b0);
    issue(1'b0, ROWS - 1, 8'h00, 1'b0);
    issue(1'b0, ROWS, 8'h00, 1'b0);
    drain();

    // req_valid held high across back-to-back requests.
    issue(1'b1, 1, 8'h11, 1'b1);
    issue(1'b0, 1, 8'h00, 1'b1);
    issue(1'b1, 2, 8'h22, 1'b1);
    issue(1'b0, 2, 8'h00, 1'b0);
    drain();

    // Randomized mix of reads, writes and bad addresses.
    for (int i = 0; i < 80; i++)
      issue(1'($urandom), int'($urandom_range(0, 15)), WORD_W'($urandom), 1'($urandom));
    req_valid = 1'b0;
    drain();

    // Reset during the second strobe cycle of a write.
    issue(1'b1, 5, 8'h3C, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_in_strobe", 32'(cell_sel), 32'h020);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_sel", 32'(cell_sel), 32'(0));
    chk("t6_rst_rw", 32'(cell_rw), 32'(0));
    chk("t6_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("t6_rst_ready", 32'(req_ready), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_ready_after_release", 32'(req_ready), 32'(1));
    // A full strobe cycle with stable data elapsed, so the latch holds it.
    ref_mem[5] = 8'h3C;
    repeat (8) @(posedge clk);
    #1;
    issue(1'b0, 5, 8'h00, 1'b0);
    issue(1'b0, 4, 8'h00, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
